// File: rtl/trap_seq.sv
// Trap-entry / mret sequencer in front of the machine-mode CSR file.
// Turns one ecall or mret request into a short, ordered run of single-port CSR operations.
module trap_seq #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_req_i,
    input  logic        mret_req_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] csr_rdata_i,
    output logic [11:0] csr_raddr_o,
    output logic        csr_wr_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        busy_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    // state   | meaning
    // IDLE    | waiting for trap_req / mret_req
    // T_EPC   | write mepc with the trapping PC
    // T_CAUSE | write mcause
    // T_STAT  | read-modify-write mstatus for trap entry
    // T_VEC   | read mtvec, issue redirect
    // M_STAT  | read-modify-write mstatus for mret
    // M_EPC   | read mepc, issue redirect
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_EPC   = 3'd1,
        T_CAUSE = 3'd2,
        T_STAT  = 3'd3,
        T_VEC   = 3'd4,
        M_STAT  = 3'd5,
        M_EPC   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] stat_mod;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        csr_raddr_o      = 12'h0;
        csr_wr_o         = 1'b0;
        csr_waddr_o      = 12'h0;
        csr_wdata_o      = 32'h0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        stat_mod         = csr_rdata_i;

        case (state_q)
            IDLE: begin
                // trap has priority; a simultaneous mret is dropped
                if (trap_req_i) begin
                    pc_d    = trap_pc_i;
                    cause_d = trap_cause_i;
                    state_d = T_EPC;
                end else if (mret_req_i) begin
                    state_d = M_STAT;
                end
            end
            T_EPC: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = MEPC_ADDR;
                csr_raddr_o = MEPC_ADDR;
                csr_wdata_o = pc_q;
                state_d     = T_CAUSE;
            end
            T_CAUSE: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = MCAUSE_ADDR;
                csr_raddr_o = MCAUSE_ADDR;
                csr_wdata_o = cause_q;
                state_d     = T_STAT;
            end
            T_STAT: begin
                stat_mod[7]     = csr_rdata_i[3];
                stat_mod[3]     = 1'b0;
                stat_mod[12:11] = 2'b11;
                csr_wr_o        = 1'b1;
                csr_waddr_o     = MSTATUS_ADDR;
                csr_raddr_o     = MSTATUS_ADDR;
                csr_wdata_o     = stat_mod;
                state_d         = T_VEC;
            end
            T_VEC: begin
                // direct mode only: mode bits of mtvec are masked off
                csr_raddr_o      = MTVEC_ADDR;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {csr_rdata_i[31:2], 2'b00};
                state_d          = IDLE;
            end
            M_STAT: begin
                stat_mod[3]     = csr_rdata_i[7];
                stat_mod[7]     = 1'b1;
                stat_mod[12:11] = 2'b11;
                csr_wr_o        = 1'b1;
                csr_waddr_o     = MSTATUS_ADDR;
                csr_raddr_o     = MSTATUS_ADDR;
                csr_wdata_o     = stat_mod;
                state_d         = M_EPC;
            end
            M_EPC: begin
                csr_raddr_o      = MEPC_ADDR;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {csr_rdata_i[31:2], 2'b00};
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq with a small behavioural CSR file model.
// Expected values are hand-computed constants.
module tb_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req, mret_req;
    logic [31:0] trap_pc, trap_cause;
    logic [31:0] csr_rdata;
    logic [11:0] csr_raddr, csr_waddr;
    logic        csr_wr;
    logic [31:0] csr_wdata;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // CSR file model
    logic [31:0] m_status = 32'h0;
    logic [31:0] m_tvec   = 32'h0;
    logic [31:0] m_epc    = 32'h0;
    logic [31:0] m_cause  = 32'h0;
    int          status_wr_cnt = 0;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    int          wr_base;

    trap_seq dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .trap_req_i       (trap_req),
        .mret_req_i       (mret_req),
        .trap_pc_i        (trap_pc),
        .trap_cause_i     (trap_cause),
        .csr_rdata_i      (csr_rdata),
        .csr_raddr_o      (csr_raddr),
        .csr_wr_o         (csr_wr),
        .csr_waddr_o      (csr_waddr),
        .csr_wdata_o      (csr_wdata),
        .busy_o           (busy),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_raddr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_wr) begin
            case (csr_waddr)
                12'h300: begin
                    m_status      <= csr_wdata;
                    status_wr_cnt <= status_wr_cnt + 1;
                end
                12'h305: m_tvec  <= csr_wdata;
                12'h341: m_epc   <= csr_wdata;
                12'h342: m_cause <= csr_wdata;
                default: ;
            endcase
        end else if (pl_en) begin
            case (pl_addr)
                12'h300: m_status <= pl_data;
                12'h305: m_tvec   <= pl_data;
                12'h341: m_epc    <= pl_data;
                12'h342: m_cause  <= pl_data;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic csr_set(input logic [11:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        trap_req   = 1'b0;
        mret_req   = 1'b0;
        trap_pc    = 32'h0;
        trap_cause = 32'h0;
        pl_en      = 1'b0;
        pl_addr    = 12'h0;
        pl_data    = 32'h0;

        smp();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_wr", {31'b0, csr_wr}, 32'h0);
        chk("rst_rv", {31'b0, redirect_valid}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            smp();
            chk("idle_busy", {31'b0, busy}, 32'h0);
            chk("idle_wr", {31'b0, csr_wr}, 32'h0);
            chk("idle_rv", {31'b0, redirect_valid}, 32'h0);
            chk("idle_rpc", redirect_pc, 32'h0);
            tick();
        end

        // trap entry
        csr_set(12'h300, 32'h0000_1808);
        csr_set(12'h305, 32'h8000_1000);
        trap_req = 1'b1; trap_pc = 32'h8000_0040; trap_cause = 32'd11;
        smp();
        chk("trap_n_busy", {31'b0, busy}, 32'h0);
        chk("trap_n_wr", {31'b0, csr_wr}, 32'h0);
        tick();
        trap_req = 1'b0;
        smp();
        chk("trap_n1_busy", {31'b0, busy}, 32'h1);
        chk("trap_n1_wr", {31'b0, csr_wr}, 32'h1);
        chk("trap_n1_waddr", {20'b0, csr_waddr}, 32'h341);
        chk("trap_n1_raddr", {20'b0, csr_raddr}, 32'h341);
        chk("trap_n1_wdata", csr_wdata, 32'h8000_0040);
        chk("trap_n1_rv", {31'b0, redirect_valid}, 32'h0);
        tick();
        smp();
        chk("trap_n2_wr", {31'b0, csr_wr}, 32'h1);
        chk("trap_n2_waddr", {20'b0, csr_waddr}, 32'h342);
        chk("trap_n2_wdata", csr_wdata, 32'd11);
        chk("trap_n2_rv", {31'b0, redirect_valid}, 32'h0);
        tick();
        smp();
        chk("trap_n3_wr", {31'b0, csr_wr}, 32'h1);
        chk("trap_n3_waddr", {20'b0, csr_waddr}, 32'h300);
        chk("trap_n3_raddr", {20'b0, csr_raddr}, 32'h300);
        chk("trap_n3_wdata", csr_wdata, 32'h0000_1880);
        chk("trap_n3_rv", {31'b0, redirect_valid}, 32'h0);
        tick();
        smp();
        chk("trap_n4_busy", {31'b0, busy}, 32'h1);
        chk("trap_n4_wr", {31'b0, csr_wr}, 32'h0);
        chk("trap_n4_raddr", {20'b0, csr_raddr}, 32'h305);
        chk("trap_n4_rv", {31'b0, redirect_valid}, 32'h1);
        chk("trap_n4_rpc", redirect_pc, 32'h8000_1000);
        tick();
        smp();
        chk("trap_n5_busy", {31'b0, busy}, 32'h0);
        chk("trap_n5_rv", {31'b0, redirect_valid}, 32'h0);
        chk("trap_mepc", m_epc, 32'h8000_0040);
        chk("trap_mcause", m_cause, 32'd11);
        chk("trap_mstatus", m_status, 32'h0000_1880);
        tick();

        // mret
        csr_set(12'h341, 32'h8000_0044);
        mret_req = 1'b1;
        smp();
        chk("mret_n_busy", {31'b0, busy}, 32'h0);
        tick();
        mret_req = 1'b0;
        smp();
        chk("mret_n1_busy", {31'b0, busy}, 32'h1);
        chk("mret_n1_wr", {31'b0, csr_wr}, 32'h1);
        chk("mret_n1_waddr", {20'b0, csr_waddr}, 32'h300);
        chk("mret_n1_wdata", csr_wdata, 32'h0000_1888);
        chk("mret_n1_rv", {31'b0, redirect_valid}, 32'h0);
        tick();
        smp();
        chk("mret_n2_wr", {31'b0, csr_wr}, 32'h0);
        chk("mret_n2_raddr", {20'b0, csr_raddr}, 32'h341);
        chk("mret_n2_rv", {31'b0, redirect_valid}, 32'h1);
        chk("mret_n2_rpc", redirect_pc, 32'h8000_0044);
        tick();
        smp();
        chk("mret_n3_busy", {31'b0, busy}, 32'h0);
        chk("mret_mstatus", m_status, 32'h0000_1888);
        tick();

        // both requests, mret pulse mid-sequence, misaligned mtvec, request in redirect cycle
        csr_set(12'h305, 32'h8000_1003);
        wr_base = status_wr_cnt;
        trap_req = 1'b1; mret_req = 1'b1; trap_pc = 32'h0000_0100; trap_cause = 32'd3;
        smp();
        tick();
        trap_req = 1'b0; mret_req = 1'b0;
        smp();
        chk("prio_n1_waddr", {20'b0, csr_waddr}, 32'h341);
        chk("prio_n1_wdata", csr_wdata, 32'h0000_0100);
        tick();
        mret_req = 1'b1;
        smp();
        chk("prio_n2_waddr", {20'b0, csr_waddr}, 32'h342);
        chk("prio_n2_wdata", csr_wdata, 32'd3);
        tick();
        mret_req = 1'b0;
        smp();
        chk("prio_n3_waddr", {20'b0, csr_waddr}, 32'h300);
        chk("prio_n3_wdata", csr_wdata, 32'h0000_1880);
        tick();
        trap_req = 1'b1; trap_pc = 32'h0000_0999; trap_cause = 32'd5;
        smp();
        chk("misal_rv", {31'b0, redirect_valid}, 32'h1);
        chk("misal_rpc", redirect_pc, 32'h8000_1000);
        tick();
        trap_req = 1'b0;
        smp();
        chk("ignore_busy", {31'b0, busy}, 32'h0);
        chk("ignore_wr", {31'b0, csr_wr}, 32'h0);
        chk("prio_stat_writes", status_wr_cnt - wr_base, 32'd1);
        chk("prio_mcause", m_cause, 32'd3);
        tick();
        smp();
        chk("ignore_busy2", {31'b0, busy}, 32'h0);
        tick();

        // asynchronous reset during T_CAUSE
        trap_req = 1'b1; trap_pc = 32'h0000_0200; trap_cause = 32'd7;
        smp();
        tick();
        trap_req = 1'b0;
        smp();
        tick();
        smp();
        chk("arst_pre_wr", {31'b0, csr_wr}, 32'h1);
        chk("arst_pre_waddr", {20'b0, csr_waddr}, 32'h342);
        #1 rst = 1'b1;
        #1;
        chk("arst_wr", {31'b0, csr_wr}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_waddr", {20'b0, csr_waddr}, 32'h0);
        chk("arst_mepc", m_epc, 32'h0000_0200);
        tick();
        smp();
        chk("arst_rv", {31'b0, redirect_valid}, 32'h0);
        chk("arst_mcause", m_cause, 32'd3);
        tick();
        rst = 1'b0;
        smp();
        chk("arst_rel_busy", {31'b0, busy}, 32'h0);
        chk("arst_rel_rv", {31'b0, redirect_valid}, 32'h0);
        tick();

        // normal trap after reset
        csr_set(12'h300, 32'h0000_0008);
        csr_set(12'h305, 32'h0000_4000);
        trap_req = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'd11;
        smp();
        tick();
        trap_req = 1'b0;
        smp();
        chk("post_n1_wdata", csr_wdata, 32'h0000_0300);
        tick();
        smp();
        chk("post_n2_wdata", csr_wdata, 32'd11);
        tick();
        smp();
        chk("post_n3_wdata", csr_wdata, 32'h0000_1880);
        tick();
        smp();
        chk("post_n4_rv", {31'b0, redirect_valid}, 32'h1);
        chk("post_n4_rpc", redirect_pc, 32'h0000_4000);
        tick();
        smp();
        chk("post_n5_busy", {31'b0, busy}, 32'h0);
        chk("post_mepc", m_epc, 32'h0000_0300);
        chk("post_mcause", m_cause, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Sequencer directly upstream of the machine-mode CSR register file. Converts a single-cycle ecall/mret request from decode into an ordered series of single-port CSR write/read operations.
- Trap entry writes mepc, writes mcause, read-modify-writes mstatus, then fetches the PC redirect from mtvec.
- mret read-modify-writes mstatus, then fetches the PC redirect from mepc.
- Holds the core stalled through `busy` while the sequence runs.

Parameters:
- MSTATUS_ADDR, 12'h300, CSR address of mstatus
- MTVEC_ADDR, 12'h305, CSR address of mtvec
- MEPC_ADDR, 12'h341, CSR address of mepc
- MCAUSE_ADDR, 12'h342, CSR address of mcause

Ports:
- clk  input  1  core clock; also drives the CSR write clock
- rst  input  1  asynchronous, active-high reset
- trap_req  input  1  decode has an ecall/exception; sampled only in IDLE
- mret_req  input  1  decode has an mret; sampled only in IDLE
- trap_pc  input  32  PC of the trapping instruction
- trap_cause  input  32  mcause value (ecall from M = 32'd11)
- csr_rdata  input  32  combinational read data from the CSR file
- csr_raddr  output  12  CSR read address
- csr_wr  output  1  CSR write enable
- csr_waddr  output  12  CSR write address
- csr_wdata  output  32  CSR write data
- busy  output  1  sequence in progress; the core must stall fetch/decode
- redirect_valid  output  1  one-cycle pulse: the next PC is redirect_pc
- redirect_pc  output  32  trap vector or return address

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC. The state register is the only clocked control.
- All outputs decode combinationally from the state, the latched registers and csr_rdata.
- Reset (asynchronous): state becomes IDLE immediately. pc_q and cause_q clear to 0. All outputs are 0 while rst is high and in IDLE.
- Reset during a sequence aborts it. CSR writes already performed stand; no redirect is issued.
- IDLE:
  - trap_req=1: latch trap_pc into pc_q and trap_cause into cause_q, then go to T_EPC.
  - mret_req=0 and trap_req=0: stay in IDLE.
  - mret_req=1 (trap_req=0): go to M_STAT.
  - Both asserted: trap wins and the mret is dropped.
  - Requests in any other state are ignored.
- busy = (state != IDLE). The accepting cycle itself is not busy. Decode must hold the requesting instruction so that it does not retire in that cycle.
- In every write state, csr_raddr = csr_waddr, so the CSR file may decode either address.
- T_EPC: csr_wr=1, waddr=MEPC_ADDR, wdata=pc_q. Next state T_CAUSE.
- T_CAUSE: csr_wr=1, waddr=MCAUSE_ADDR, wdata=cause_q. Next state T_STAT.
- T_STAT: raddr=waddr=MSTATUS_ADDR, csr_wr=1. Next state T_VEC. wdata is csr_rdata with:
  - bit7 (MPIE) = csr_rdata[3]
  - bit3 (MIE) = 0
  - bits[12:11] (MPP) = 2'b11
  - all other bits unchanged
- T_VEC: raddr=MTVEC_ADDR, csr_wr=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}. Direct mode only; mtvec bits[1:0] are ignored. Next state IDLE.
- M_STAT: raddr=waddr=MSTATUS_ADDR, csr_wr=1. Next state M_EPC. wdata is csr_rdata with:
  - bit3 = csr_rdata[7]
  - bit7 = 1
  - bits[12:11] = 2'b11 (M-only core)
- M_EPC: raddr=MEPC_ADDR, csr_wr=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}. Next state IDLE.
- Latency measured from the accepting cycle N:
  - trap: redirect_valid in cycle N+4, busy high for N+1..N+4.
  - mret: redirect_valid in cycle N+2, busy high for N+1..N+2.
- A new request can be accepted in the cycle immediately after the redirect.
- Outside the states listed above, csr_wr=0, csr_raddr=0, csr_waddr=0, csr_wdata=0, redirect_valid=0, redirect_pc=0.
- A request arriving in the redirect cycle is ignored; it is not queued.

Test Plan:
- Reset then idle: rst pulse, no requests -> busy=0, csr_wr=0, redirect_valid=0, redirect_pc=0 for 10 cycles.
- Trap entry:
  - Setup: mstatus=0x1808, mtvec=0x80001000; in cycle N, trap_req=1, trap_pc=0x80000040, trap_cause=11.
  - Required: writes mepc=0x80000040 in N+1, mcause=11 in N+2, mstatus=0x1880 in N+3.
  - Required: redirect_valid=1 with redirect_pc=0x80001000 in N+4 only; busy high for N+1..N+4.
- mret:
  - Setup: mstatus=0x1880, mepc=0x80000044; mret_req=1 in cycle N.
  - Required: mstatus written as 0x1888 in N+1; redirect_pc=0x80000044 in N+2; busy low in N+3.
- Priority and ignore:
  - trap_req and mret_req both high in IDLE -> trap sequence only.
  - mret_req pulsed in T_CAUSE -> ignored, no extra mstatus write.
- Misaligned vector: mtvec=0x80001003 -> redirect_pc=0x80001000.
- Reset mid-sequence:
  - Stimulus: assert rst asynchronously during T_CAUSE.
  - Required: csr_wr and busy drop without a clock edge; mepc keeps its new value; no redirect is issued; the next trap after reset completes normally.
